// File: rtl/mpi_pkg.sv
// Shared definitions for the MPI register-path front-end.
package mpi_pkg;

    localparam int MPI_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUAL    = 3'd1,
        WRITE   = 3'd2,
        RD_WAIT = 3'd3,
        HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/mpi_sync_filt.sv
// Two-flop synchroniser followed by a FILT-cycle deglitch filter; idles high.
module mpi_sync_filt #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    logic       s1;
    logic       s2;
    logic [2:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            cnt   <= 3'd0;
            level <= 1'b1;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any cycle where the synchronised input agrees with the output restarts the run.
            if (s2 != level) begin
                if (cnt == 3'(FILT - 1)) begin
                    level <= s2;
                    cnt   <= 3'd0;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end else begin
                cnt <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/mpi_bus_sync.sv
// Synchronises the asynchronous CPU local bus into clk100m and issues single-cycle
// register strobes, returns read data with a ready flag, and flags hung bus cycles.
module mpi_bus_sync
    import mpi_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int FILT   = 3,
    parameter int RD_LAT = 2,
    parameter int TMO    = 1000
) (
    input  logic                  clk100m,
    input  logic                  rst,
    input  logic                  mpi_cs_n,
    input  logic                  mpi_we_n,
    input  logic                  mpi_oe_n,
    input  logic [ADDR_W-1:0]     mpi_addr,
    input  logic [MPI_DATA_W-1:0] mpi_din,
    input  logic [MPI_DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0]     cpu_addr,
    output logic [MPI_DATA_W-1:0] cpu_wdata,
    output logic                  cpu_wen,
    output logic                  cpu_ren,
    output logic [MPI_DATA_W-1:0] mpi_dout,
    output logic                  mpi_dout_en,
    output logic                  mpi_rdy,
    output logic                  tmo_pulse,
    output logic [7:0]            tmo_cnt
);

    localparam int TMR_W = $clog2(TMO) + 1;

    logic             cs_f;
    logic             we_f;
    logic             oe_f;
    logic             cs_act;
    logic             we_act;
    logic             oe_act;
    state_t           state;
    logic [2:0]       rd_cnt;
    logic [TMR_W-1:0] tmr;
    logic             fired;

    mpi_sync_filt #(.FILT(FILT)) u_cs (.clk(clk100m), .rst(rst), .raw(mpi_cs_n), .level(cs_f));
    mpi_sync_filt #(.FILT(FILT)) u_we (.clk(clk100m), .rst(rst), .raw(mpi_we_n), .level(we_f));
    mpi_sync_filt #(.FILT(FILT)) u_oe (.clk(clk100m), .rst(rst), .raw(mpi_oe_n), .level(oe_f));

    assign cs_act = ~cs_f;
    assign we_act = ~we_f;
    assign oe_act = ~oe_f;

    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_cnt      <= 3'd0;
            tmr         <= '0;
            fired       <= 1'b0;
            cpu_addr    <= '0;
            cpu_wdata   <= '0;
            cpu_wen     <= 1'b0;
            cpu_ren     <= 1'b0;
            mpi_dout    <= '0;
            mpi_dout_en <= 1'b0;
            mpi_rdy     <= 1'b0;
            tmo_pulse   <= 1'b0;
            tmo_cnt     <= 8'd0;
        end else begin
            cpu_wen   <= 1'b0;
            cpu_ren   <= 1'b0;
            tmo_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    mpi_rdy     <= 1'b0;
                    mpi_dout_en <= 1'b0;
                    if (cs_act) state <= QUAL;
                end
                QUAL: begin
                    cpu_addr <= mpi_addr;
                    if (we_act) begin
                        cpu_wdata <= mpi_din;
                        cpu_wen   <= 1'b1;
                        state     <= WRITE;
                    end else if (oe_act) begin
                        cpu_ren <= 1'b1;
                        rd_cnt  <= 3'd0;
                        state   <= RD_WAIT;
                    end else if (!cs_act) begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    mpi_rdy <= 1'b1;
                    state   <= HOLD;
                end
                RD_WAIT: begin
                    // Data is presented RD_LAT cycles after cpu_ren and sampled at the end of that cycle.
                    if (!cs_act) begin
                        state <= IDLE;
                    end else if (rd_cnt == 3'(RD_LAT)) begin
                        mpi_dout    <= cpu_rdata;
                        mpi_dout_en <= 1'b1;
                        mpi_rdy     <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        rd_cnt <= rd_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (!cs_act) begin
                        mpi_rdy     <= 1'b0;
                        mpi_dout_en <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Timeout watchdog: one pulse per access, never alters the FSM.
            if (state == IDLE) begin
                tmr   <= '0;
                fired <= 1'b0;
            end else if (tmr == TMR_W'(TMO - 1)) begin
                if (!fired) begin
                    fired     <= 1'b1;
                    tmo_pulse <= 1'b1;
                    if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
                end
            end else begin
                tmr <= tmr + TMR_W'(1);
            end
        end
    end

endmodule
